post_adder_acc: RTL and testbench

POST_ADDER_ACC -- requirements
Module: post_adder_acc

---
 rtl/post_adder_acc.sv | 128 ++++++++++++
 tb/tb_post_adder_acc.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/post_adder_acc.sv
// Post-adder / accumulator: Z +/- (X + cin) over 48 bits with a registered P stage.
// Optional saturation on signed overflow is enabled with the POST_ADDER_SAT_EN macro.
module post_adder_acc #(
    parameter string CARRYINSEL = "OPMODE5",
    parameter int    PREG       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_opmode,
    input  logic        ce_carryin,
    input  logic        ce_p,
    input  logic [7:0]  opmode,
    input  logic [35:0] m,
    input  logic [47:0] dab,
    input  logic [47:0] c,
    input  logic [47:0] pcin,
    input  logic        carryin,
    output logic [47:0] p,
    output logic [47:0] pcout,
    output logic        carryout,
    output logic        ovf
);
    localparam bit USE_CARRYIN = (CARRYINSEL == "CARRYIN");

    logic [7:0]  opmode_r;
    logic        cin_r;
    logic [47:0] p_r;
    logic        carryout_r;
    logic        ovf_r;

    logic [47:0] x_mux;
    logic [47:0] z_mux;
    logic        cin;
    logic [48:0] sum_raw;
    logic [47:0] p_nxt;
    logic        ovf_nxt;

    // opmode[4] and [6] carry no function in this slice
    logic unused_opmode_bits;
    assign unused_opmode_bits = opmode_r[6] ^ opmode_r[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            opmode_r <= '0;
            cin_r    <= 1'b0;
        end else begin
            if (ce_opmode)
                opmode_r <= opmode;
            if (ce_carryin)
                cin_r <= carryin;
        end
    end

    assign cin = USE_CARRYIN ? cin_r : opmode_r[5];

    // Feedback always comes from the P register; with PREG=0 feedback selects are illegal
    always_comb begin
        x_mux = '0;
        case (opmode_r[1:0])
            2'd0: x_mux = '0;
            2'd1: x_mux = {12'd0, m};
            2'd2: x_mux = p_r;
            2'd3: x_mux = dab;
            default: x_mux = '0;
        endcase
        z_mux = '0;
        case (opmode_r[3:2])
            2'd0: z_mux = '0;
            2'd1: z_mux = pcin;
            2'd2: z_mux = p_r;
            2'd3: z_mux = c;
            default: z_mux = '0;
        endcase
    end

    always_comb begin
        if (opmode_r[7])
            sum_raw = {1'b0, z_mux} - {1'b0, x_mux} - {48'd0, cin};
        else
            sum_raw = {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, cin};
    end

`ifdef POST_ADDER_SAT_EN
    // Exact signed result in 50 bits; overflow when it does not fit in 48
    logic signed [49:0] sum_s;
    always_comb begin
        if (opmode_r[7])
            sum_s = $signed({{2{z_mux[47]}}, z_mux}) - $signed({{2{x_mux[47]}}, x_mux})
                    - $signed({49'd0, cin});
        else
            sum_s = $signed({{2{z_mux[47]}}, z_mux}) + $signed({{2{x_mux[47]}}, x_mux})
                    + $signed({49'd0, cin});
        ovf_nxt = (sum_s[49:47] != 3'b000) && (sum_s[49:47] != 3'b111);
        p_nxt   = sum_raw[47:0];
        if (ovf_nxt)
            p_nxt = sum_s[49] ? 48'h8000_0000_0000 : 48'h7FFF_FFFF_FFFF;
    end
`else
    assign ovf_nxt = 1'b0;
    assign p_nxt   = sum_raw[47:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            p_r        <= '0;
            carryout_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else if (ce_p) begin
            p_r        <= p_nxt;
            carryout_r <= sum_raw[48];
            ovf_r      <= ovf_nxt;
        end
    end

    generate
        if (PREG != 0) begin : g_preg
            assign p        = p_r;
            assign carryout = carryout_r;
            assign ovf      = ovf_r;
        end else begin : g_pcomb
            assign p        = p_nxt;
            assign carryout = sum_raw[48];
            assign ovf      = ovf_nxt;
        end
    endgenerate

    assign pcout = p;
endmodule

// File: tb/tb_post_adder_acc.sv
// Directed bench for post_adder_acc: vector table for single-shot ops plus hand sequences for accumulate/hold/reset.
module tb_post_adder_acc;
    logic        clk = 1'b0;
    logic        rst;
    logic        ce_opmode, ce_carryin, ce_p;
    logic [7:0]  opmode;
    logic [35:0] m;
    logic [47:0] dab, c, pcin;
    logic        carryin;
    logic [47:0] p, pcout;
    logic        carryout, ovf;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    post_adder_acc dut (
        .clk(clk), .rst(rst), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin), .ce_p(ce_p),
        .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
        .p(p), .pcout(pcout), .carryout(carryout), .ovf(ovf)
    );

    typedef struct {
        logic [7:0]  op;
        logic [35:0] m;
        logic [47:0] dab;
        logic [47:0] c;
        logic [47:0] pcin;
        logic [47:0] exp_p;
        logic        exp_co;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_p(input string name, input logic [47:0] exp);
        chk({name, ".p"}, p, exp);
        chk({name, ".pcout"}, pcout, exp);
    endtask

    initial begin
        logic [47:0] sat_p;
        logic        sat_ovf;
`ifdef POST_ADDER_SAT_EN
        sat_p = 48'h7FFF_FFFF_FFFF; sat_ovf = 1'b1;
`else
        sat_p = 48'h8000_0000_0000; sat_ovf = 1'b0;
`endif
        //        op     m                dab                  c                    pcin                 exp_p                co    ovf
        vecs[0] = '{8'hAD, 36'd30,         48'd0,               48'd100,             48'd0,               48'd69,              1'b0, 1'b0};
        vecs[1] = '{8'h0F, 36'd0,          48'hFFFF_FFFF_FFFF,  48'hFFFF_FFFF_FFFF,  48'd0,               48'hFFFF_FFFF_FFFE,  1'b1, 1'b0};
        vecs[2] = '{8'h05, 36'd24,         48'd0,               48'd0,               48'd1000,            48'd1024,            1'b0, 1'b0};
        vecs[3] = '{8'h0C, 36'd7,          48'd5,               48'd123,             48'd9,               48'd123,             1'b0, 1'b0};
        vecs[4] = '{8'h8F, 36'd0,          48'd20,              48'd10,              48'd0,               48'hFFFF_FFFF_FFF6,  1'b1, 1'b0};
        vecs[5] = '{8'h2C, 36'd0,          48'd0,               48'hFFFF_FFFF_FFFF,  48'd0,               48'd0,               1'b1, 1'b0};
        vecs[6] = '{8'h07, 36'd0,          48'd1,               48'd0,               48'h7FFF_FFFF_FFFF,  sat_p,               1'b0, sat_ovf};
        vecs[7] = '{8'h0D, 36'hF_FFFF_FFFF, 48'd0,              48'd1,               48'd0,               48'h10_0000_0000,    1'b0, 1'b0};
        vecs[8] = '{8'hD0, 36'd3,          48'd3,               48'd3,               48'd3,               48'd0,               1'b0, 1'b0};

        // Reset with every input non-zero
        rst = 1'b1; ce_opmode = 1'b1; ce_carryin = 1'b1; ce_p = 1'b1;
        opmode = 8'hFF; m = 36'd77; dab = 48'd55; c = 48'd66; pcin = 48'd88; carryin = 1'b1;
        tick();
        chk_p("reset", 48'd0);
        chk("reset.carryout", {47'd0, carryout}, 48'd0);
        chk("reset.ovf", {47'd0, ovf}, 48'd0);
        // Opmode register cleared: a free-running edge still yields 0+0+0
        rst = 1'b0; ce_opmode = 1'b0;
        tick();
        chk_p("reset.opmode_zero", 48'd0);

        // Table-driven single operations: load opmode, then one enabled P edge
        for (int i = 0; i < 9; i++) begin
            opmode = vecs[i].op; m = vecs[i].m; dab = vecs[i].dab;
            c = vecs[i].c; pcin = vecs[i].pcin;
            ce_opmode = 1'b1; ce_p = 1'b0;
            tick();
            ce_opmode = 1'b0; ce_p = 1'b1;
            tick();
            chk_p($sformatf("vec%0d", i), vecs[i].exp_p);
            chk($sformatf("vec%0d.carryout", i), {47'd0, carryout}, {47'd0, vecs[i].exp_co});
            chk($sformatf("vec%0d.ovf", i), {47'd0, ovf}, {47'd0, vecs[i].exp_ovf});
        end

        // Accumulate m=5 from zero
        rst = 1'b1; tick(); rst = 1'b0;
        opmode = 8'h09; m = 36'd5; ce_opmode = 1'b1; ce_p = 1'b0;
        tick();
        ce_opmode = 1'b0; ce_p = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_p($sformatf("acc%0d", k), 48'(5 * k));
        end

        // Hold with ce_p low
        ce_p = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_p($sformatf("hold%0d", k), 48'd25);
        end

        // New opmode presented but not enabled: still accumulating
        opmode = 8'h0C; c = 48'd999; ce_opmode = 1'b0; ce_p = 1'b1;
        tick();
        chk_p("opmode_hold", 48'd30);

        // Opmode load and P update on the same edge use the old opmode
        opmode = 8'h00; ce_opmode = 1'b1;
        tick();
        chk_p("same_edge_old_op", 48'd35);
        ce_opmode = 1'b0;
        tick();
        chk_p("same_edge_new_op", 48'd0);

        // Reset mid-accumulation, glitch between edges, resume
        opmode = 8'h09; ce_opmode = 1'b1; ce_p = 1'b0;
        tick();
        ce_opmode = 1'b0; ce_p = 1'b1;
        tick(); tick();
        chk_p("pre_rst", 48'd10);
        rst = 1'b1;
        tick();
        chk_p("mid_rst", 48'd0);
        rst = 1'b0; ce_opmode = 1'b1; ce_p = 1'b0;
        tick();
        ce_opmode = 1'b0; ce_p = 1'b1;
        tick();
        chk_p("resume1", 48'd5);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        chk_p("rst_between_edges", 48'd5);
        tick();
        chk_p("resume2", 48'd10);

        // Cascade then reset mid-sequence
        opmode = 8'h05; pcin = 48'd1000; m = 36'd24; ce_opmode = 1'b1; ce_p = 1'b0;
        tick();
        ce_opmode = 1'b0; ce_p = 1'b1;
        tick();
        chk_p("cascade", 48'd1024);
        rst = 1'b1;
        tick();
        chk_p("cascade_rst", 48'd0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
